crc8_check: RTL and testbench

//  Receive-side CRC-8 checker; sits directly downstream of the CRC-8 appender.

---
 rtl/crc8_check_if.sv | 11 +
 rtl/crc8_check.sv | 121 ++++++++++++
 tb/tb_crc8_check.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc8_check_if.sv
// Byte-stream bundle for crc8_check: input byte stream and stripped payload stream.
interface crc8_check_if;
  logic       din_vld;
  logic [7:0] din;
  logic       dout_vld;
  logic [7:0] dout;
  logic       dout_sop;

  modport master (output din_vld, din, input dout_vld, dout, dout_sop);
  modport slave  (input din_vld, din, output dout_vld, dout, dout_sop);
endinterface

// File: rtl/crc8_check.sv
// Receive-side CRC-8 (poly 0x07, init 0, MSB-first) checker: strips the trailing
// CRC byte, forwards payload, reports per-frame status and saturating counters.
module crc8_check #(
  parameter int unsigned MAX_LEN = 1500,
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  crc8_check_if.slave      s,
  input  logic             clr_cnt,
  output logic             frame_done,
  output logic             crc_ok,
  output logic             len_err,
  output logic [LEN_W-1:0] frame_len,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt
);

  // One spare bit so the byte count can exceed the frame_len range before saturating.
  localparam int unsigned CW = LEN_W + 1;
  localparam logic [CW-1:0] MAX_LEN_C = CW'(MAX_LEN);

  typedef enum logic [1:0] {SYNC, IDLE, RECV} state_t;
  state_t state, state_nxt;

  logic          accept, fwd, fin;
  logic [7:0]    hold_q;
  logic          hold_vld;
  logic [7:0]    crc_q;
  logic [CW-1:0] byte_cnt;
  logic [CW-1:0] payload_len;
  logic          len_err_c;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] x;
    x = c ^ d;
    for (int unsigned i = 0; i < 8; i++)
      x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
    return x;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SYNC;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    fwd       = 1'b0;
    fin       = 1'b0;
    case (state)
      SYNC: if (!s.din_vld) state_nxt = IDLE;
      IDLE: if (s.din_vld) begin
        state_nxt = RECV;
        accept    = 1'b1;
      end
      RECV: if (s.din_vld) begin
        accept = 1'b1;
        fwd    = hold_vld;
      end else begin
        state_nxt = IDLE;
        fin       = 1'b1;
      end
      default: state_nxt = SYNC;
    endcase
  end

  assign payload_len = byte_cnt - 1'b1;
  assign len_err_c   = payload_len > MAX_LEN_C;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q     <= '0;
      hold_vld   <= 1'b0;
      crc_q      <= '0;
      byte_cnt   <= '0;
      s.dout_vld <= 1'b0;
      s.dout     <= '0;
      s.dout_sop <= 1'b0;
      frame_done <= 1'b0;
      crc_ok     <= 1'b0;
      len_err    <= 1'b0;
      frame_len  <= '0;
    end else begin
      s.dout_vld <= fwd;
      s.dout_sop <= fwd && (byte_cnt == CW'(1));
      frame_done <= fin;
      if (fwd) s.dout <= hold_q;
      if (accept) begin
        hold_q   <= s.din;
        hold_vld <= 1'b1;
        crc_q    <= crc8_step((state == IDLE) ? 8'h00 : crc_q, s.din);
        if (state == IDLE)      byte_cnt <= CW'(1);
        else if (byte_cnt != '1) byte_cnt <= byte_cnt + 1'b1;
      end
      // The held byte at frame end is the CRC itself and is dropped.
      if (fin) begin
        hold_vld  <= 1'b0;
        len_err   <= len_err_c;
        crc_ok    <= (crc_q == 8'h00) && (byte_cnt != CW'(1)) && !len_err_c;
        frame_len <= payload_len[CW-1] ? '1 : payload_len[LEN_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (clr_cnt) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (frame_done) begin
      if (crc_ok && good_cnt != '1)  good_cnt <= good_cnt + 1'b1;
      if (!crc_ok && bad_cnt != '1)  bad_cnt  <= bad_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_crc8_check.sv
// Scoreboard bench for crc8_check: default instance plus MAX_LEN=3 and CNT_W=2 variants.
module tb_crc8_check;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din_vld = 1'b0;
  logic       clr_cnt = 1'b0;
  logic [7:0] din = 8'h00;

  always #5 clk = ~clk;

  crc8_check_if if0 ();
  crc8_check_if if1 ();
  crc8_check_if if2 ();
  assign if0.din_vld = din_vld;
  assign if0.din     = din;
  assign if1.din_vld = din_vld;
  assign if1.din     = din;
  assign if2.din_vld = din_vld;
  assign if2.din     = din;

  logic        fd0, ok0, le0, fd1, ok1, le1, fd2, ok2, le2;
  logic [15:0] fl0, fl1, fl2, gc0, bc0, gc1, bc1;
  logic [1:0]  gc2, bc2;

  crc8_check #(.MAX_LEN(1500), .LEN_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .s(if0), .clr_cnt(clr_cnt), .frame_done(fd0),
    .crc_ok(ok0), .len_err(le0), .frame_len(fl0), .good_cnt(gc0), .bad_cnt(bc0));
  crc8_check #(.MAX_LEN(3), .LEN_W(16), .CNT_W(16)) dut_len (
    .clk(clk), .rst_n(rst_n), .s(if1), .clr_cnt(clr_cnt), .frame_done(fd1),
    .crc_ok(ok1), .len_err(le1), .frame_len(fl1), .good_cnt(gc1), .bad_cnt(bc1));
  crc8_check #(.MAX_LEN(1500), .LEN_W(16), .CNT_W(2)) dut_cnt (
    .clk(clk), .rst_n(rst_n), .s(if2), .clr_cnt(clr_cnt), .frame_done(fd2),
    .crc_ok(ok2), .len_err(le2), .frame_len(fl2), .good_cnt(gc2), .bad_cnt(bc2));

  typedef struct { logic [7:0] b; logic sop; } byte_t;
  typedef struct { logic ok; logic le; logic [15:0] len; } stat_t;
  byte_t byte_q[$];
  stat_t stat_q[$];
  logic [7:0] frm[$];

  int errors = 0;
  int checks = 0;
  int exp_good = 0, exp_bad = 0, exp_good2 = 0;
  int n1 = 0;

  function automatic logic [7:0] ref_crc(input logic [7:0] f[$]);
    logic [7:0] c;
    logic fb;
    c = 8'h00;
    foreach (f[k])
      for (int i = 7; i >= 0; i--) begin
        fb = c[7] ^ f[k][i];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    return c;
  endfunction

  // Scoreboard monitor for the default instance
  always @(negedge clk) begin
    byte_t eb;
    stat_t es;
    if (if0.dout_vld) begin
      checks++;
      if (byte_q.size() == 0) begin
        errors++;
        $display("FAIL dout_unexpected: got %h sop=%b, required no output", if0.dout, if0.dout_sop);
      end else begin
        eb = byte_q.pop_front();
        if ({if0.dout, if0.dout_sop} !== {eb.b, eb.sop}) begin
          errors++;
          $display("FAIL dout: got %h sop=%b, required %h sop=%b", if0.dout, if0.dout_sop, eb.b, eb.sop);
        end
      end
    end else if (if0.dout_sop) begin
      checks++;
      errors++;
      $display("FAIL sop_without_vld: got sop=1, required 0");
    end
    if (fd0) begin
      checks++;
      if (stat_q.size() == 0) begin
        errors++;
        $display("FAIL frame_done_unexpected: got frame_done=1, required 0");
      end else begin
        es = stat_q.pop_front();
        if ({ok0, le0, fl0} !== {es.ok, es.le, es.len}) begin
          errors++;
          $display("FAIL status: got ok=%b le=%b len=%0d, required ok=%b le=%b len=%0d",
                   ok0, le0, fl0, es.ok, es.le, es.len);
        end
      end
    end
    if (if1.dout_vld) n1++;
  end

  task automatic send_frame(input logic ok);
    byte_t eb;
    stat_t es;
    for (int i = 0; i < frm.size() - 1; i++) begin
      eb.b = frm[i]; eb.sop = (i == 0);
      byte_q.push_back(eb);
    end
    es.ok = ok; es.le = 1'b0; es.len = 16'(frm.size() - 1);
    stat_q.push_back(es);
    if (ok) begin
      exp_good++;
      exp_good2 = (exp_good2 < 3) ? exp_good2 + 1 : 3;
    end else exp_bad++;
    foreach (frm[i]) begin
      @(posedge clk); #1;
      din_vld = 1'b1;
      din     = frm[i];
    end
    @(posedge clk); #1;
    din_vld = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (byte_q.size() != 0 || stat_q.size() != 0); i++) @(posedge clk);
    checks++;
    if (byte_q.size() != 0 || stat_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d bytes %0d status pending, required 0", byte_q.size(), stat_q.size());
      byte_q.delete();
      stat_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({if0.dout_vld, if0.dout, if0.dout_sop, fd0, ok0, le0} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got vld=%b dout=%h sop=%b fd=%b ok=%b le=%b, required all 0",
               if0.dout_vld, if0.dout, if0.dout_sop, fd0, ok0, le0);
    end
    checks++;
    if ({fl0, gc0, bc0} !== 48'd0) begin
      errors++;
      $display("FAIL reset_counts: got len=%0d good=%0d bad=%0d, required 0 0 0", fl0, gc0, bc0);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_good_frame();
    frm = '{8'h03, 8'h00, 8'h01, 8'h02, 8'h21};
    send_frame(1'b1);
    @(posedge clk); #1;
    checks++;
    if (fd0 !== 1'b1) begin
      errors++;
      $display("FAIL done_latency: got frame_done=%b, required 1", fd0);
    end
    drain();
    checks++;
    if (gc0 !== 16'(exp_good)) begin
      errors++;
      $display("FAIL good_cnt_1: got %0d, required %0d", gc0, exp_good);
    end
  endtask

  task automatic test_bad_frame();
    frm = '{8'h03, 8'h00, 8'h01, 8'h02, 8'h22};
    send_frame(1'b0);
    drain();
    checks++;
    if (bc0 !== 16'(exp_bad)) begin
      errors++;
      $display("FAIL bad_cnt_1: got %0d, required %0d", bc0, exp_bad);
    end
  endtask

  task automatic test_runt();
    frm = '{8'h00};
    send_frame(1'b0);
    drain();
    checks++;
    if (bc0 !== 16'(exp_bad)) begin
      errors++;
      $display("FAIL runt_bad_cnt: got %0d, required %0d", bc0, exp_bad);
    end
  endtask

  task automatic test_back_to_back();
    frm = '{8'h01, 8'h07};
    send_frame(1'b1);
    frm = '{8'h03, 8'h00, 8'h01, 8'h02, 8'h21};
    send_frame(1'b1);
    drain();
    checks++;
    if ({gc0, bc0} !== {16'(exp_good), 16'(exp_bad)}) begin
      errors++;
      $display("FAIL b2b_counts: got good=%0d bad=%0d, required %0d %0d", gc0, bc0, exp_good, exp_bad);
    end
  endtask

  task automatic test_random();
    logic [7:0] c;
    for (int k = 0; k < 6; k++) begin
      frm.delete();
      for (int i = 0; i < $urandom_range(1, 7); i++) frm.push_back(8'($urandom));
      c = ref_crc(frm);
      if (k % 2 == 1) c = c ^ 8'h5A;
      frm.push_back(c);
      send_frame(k % 2 == 0);
    end
    drain();
    checks++;
    if ({gc0, bc0} !== {16'(exp_good), 16'(exp_bad)}) begin
      errors++;
      $display("FAIL random_counts: got good=%0d bad=%0d, required %0d %0d", gc0, bc0, exp_good, exp_bad);
    end
  endtask

  task automatic test_reset_midframe();
    @(posedge clk); #1; din_vld = 1'b1; din = 8'h03;
    @(posedge clk); #1; din = 8'h00;
    @(posedge clk); #1; din = 8'h01;
    rst_n = 1'b0;
    exp_good = 0; exp_bad = 0; exp_good2 = 0;
    #1;
    checks++;
    if ({if0.dout_vld, fd0, gc0, bc0} !== 34'd0) begin
      errors++;
      $display("FAIL midreset_clear: got vld=%b fd=%b good=%0d bad=%0d, required all 0",
               if0.dout_vld, fd0, gc0, bc0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = 8'(8'h10 + i);
      @(posedge clk); #1;
      checks++;
      if ({if0.dout_vld, fd0} !== 2'b00) begin
        errors++;
        $display("FAIL sync_hold: got vld=%b fd=%b, required 0 0", if0.dout_vld, fd0);
      end
    end
    din_vld = 1'b0;
    frm = '{8'h01, 8'h07};
    send_frame(1'b1);
    drain();
    checks++;
    if ({gc0, bc0} !== {16'd1, 16'd0}) begin
      errors++;
      $display("FAIL midreset_recover: got good=%0d bad=%0d, required 1 0", gc0, bc0);
    end
  endtask

  task automatic test_len_err();
    n1 = 0;
    frm = '{8'h03, 8'h00, 8'h01, 8'h02, 8'h21};
    send_frame(1'b1);
    @(posedge clk); #1;
    checks++;
    if ({fd1, le1, ok1, fl1} !== {1'b1, 1'b1, 1'b0, 16'd4}) begin
      errors++;
      $display("FAIL len_err_status: got fd=%b le=%b ok=%b len=%0d, required 1 1 0 4", fd1, le1, ok1, fl1);
    end
    drain();
    checks++;
    if (n1 !== 4) begin
      errors++;
      $display("FAIL len_err_forward: got %0d bytes, required 4", n1);
    end
  endtask

  task automatic test_cnt_sat();
    @(posedge clk); #1; clr_cnt = 1'b1;
    @(posedge clk); #1; clr_cnt = 1'b0;
    exp_good = 0; exp_bad = 0; exp_good2 = 0;
    checks++;
    if ({gc0, bc0, gc2} !== 34'd0) begin
      errors++;
      $display("FAIL clr_cnt: got good=%0d bad=%0d good2=%0d, required 0", gc0, bc0, gc2);
    end
    for (int k = 0; k < 5; k++) begin
      frm = '{8'h01, 8'h07};
      send_frame(1'b1);
    end
    drain();
    checks++;
    if (gc2 !== 2'(exp_good2)) begin
      errors++;
      $display("FAIL cnt_saturate: got %0d, required %0d", gc2, exp_good2);
    end
    checks++;
    if (gc0 !== 16'(exp_good)) begin
      errors++;
      $display("FAIL cnt_five: got %0d, required %0d", gc0, exp_good);
    end
    // Clear lands on the same edge as the increment from this frame.
    frm = '{8'h01, 8'h07};
    send_frame(1'b1);
    @(posedge clk); #1; clr_cnt = 1'b1;
    @(posedge clk); #1; clr_cnt = 1'b0;
    exp_good = 0; exp_good2 = 0;
    drain();
    checks++;
    if ({gc0, gc2} !== 18'd0) begin
      errors++;
      $display("FAIL clr_wins: got good=%0d good2=%0d, required 0 0", gc0, gc2);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_frame();
    test_runt();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    test_len_err();
    test_cnt_sat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end
endmodule
